// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//
// Port B bundle between the memory-access stage and the scratch-pad memory.
// The SPM samples these signals on the falling edge of the pipeline clock.
//
//   spm_addr     word address (byte address [31:2])
//   spm_as_      address strobe, active-low
//   spm_rw       1 = READ, 0 = WRITE
//   spm_wr_data  write data
//   spm_rd_data  read data returned by the SPM
//
// Modports: master = mem_stage side, slave = SPM side.
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic [29:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] spm_rd_data;

  modport master (
    output spm_addr,
    output spm_as_,
    output spm_rw,
    output spm_wr_data,
    input  spm_rd_data
  );

  modport slave (
    input  spm_addr,
    input  spm_as_,
    input  spm_rw,
    input  spm_wr_data,
    output spm_rd_data
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the five-stage pipeline. Consumes the EX/MEM register,
// drives SPM port B and registers the MEM/WB outputs feeding the GPR write
// port. Little-endian memory.
//   - aligned word loads/stores go straight to the SPM;
//   - sub-word loads pick and extend a lane of the read word;
//   - sub-word stores (STB/STH) are a two-cycle read-modify-write: the first
//     cycle reads the word and raises busy, the second writes the merged word.
//
// Ports:
//   clk             pipeline clock (the SPM runs on its inverse)
//   reset           asynchronous reset, active-low
//   stall           hold MEM/WB and suppress SPM access
//   flush           load a bubble into MEM/WB, abort a pending RMW
//   ex_en .. ex_out EX/MEM pipeline register contents
//   spm             SPM port B (mem_stage_if.master)
//   busy            combinational stall request to upstream stages
//   miss_align      registered misalignment flag
//   mem_en, mem_dst_addr, mem_gpr_we_, mem_out   MEM/WB register
//
// Build option:
//   MEM_MISALIGN_CHK_EN  when defined, misaligned LDW/STW/LDH/LDHU/STH perform
//                        no SPM access, raise miss_align and block the GPR
//                        write. When undefined, the offending low address bits
//                        are ignored and miss_align stays 0.
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [31:0] ex_out,
  mem_stage_if.master spm,
  output logic        busy,
  output logic        miss_align,
  output logic        mem_en,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [31:0] mem_out
);

  typedef enum logic [3:0] {
    MEM_OP_NOP  = 4'd0,
    MEM_OP_LDW  = 4'd1,
    MEM_OP_LDH  = 4'd2,
    MEM_OP_LDHU = 4'd3,
    MEM_OP_LDB  = 4'd4,
    MEM_OP_LDBU = 4'd5,
    MEM_OP_STW  = 4'd6,
    MEM_OP_STH  = 4'd7,
    MEM_OP_STB  = 4'd8
  } mem_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  localparam logic SPM_READ  = 1'b1;
  localparam logic SPM_WRITE = 1'b0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q,        state_d;
  logic [31:0] merge_q,        merge_d;
  logic        mem_en_q,       mem_en_d;
  logic [4:0]  mem_dst_addr_q, mem_dst_addr_d;
  logic        mem_gpr_we_q,   mem_gpr_we_d;
  logic [31:0] mem_out_q,      mem_out_d;
  logic        miss_align_q,   miss_align_d;

  // ---------------------------------------------------------------------------
  // Op decode and access qualification
  // ---------------------------------------------------------------------------
  mem_op_e op;
  logic    is_load;
  logic    is_store;
  logic    is_sub_store;
  logic    miss;
  logic    access_ok;

  assign op = mem_op_e'(ex_mem_op);

  always_comb begin
    is_load      = op inside {MEM_OP_LDW, MEM_OP_LDH, MEM_OP_LDHU,
                              MEM_OP_LDB, MEM_OP_LDBU};
    is_sub_store = op inside {MEM_OP_STH, MEM_OP_STB};
    is_store     = is_sub_store || (op == MEM_OP_STW);
`ifdef MEM_MISALIGN_CHK_EN
    miss = ((op inside {MEM_OP_LDW, MEM_OP_STW}) && (ex_out[1:0] != 2'b00)) ||
           ((op inside {MEM_OP_LDH, MEM_OP_LDHU, MEM_OP_STH}) && ex_out[0]);
`else
    miss = 1'b0;
`endif
    // The reset term keeps the strobe and busy quiet for as long as reset is
    // held, not just until the first clock edge.
    access_ok = reset && ex_en && (is_load || is_store) &&
                !stall && !flush && !miss;
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and store-lane merge
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  always_comb begin
    // NOTE: every variable assigned in an always_comb gets a default on entry,
    // so no path through the case/if tree can leave it unassigned and infer a
    // latch.
    byte_sel   = spm.spm_rd_data[7:0];
    half_sel   = spm.spm_rd_data[15:0];
    load_data  = ex_out;
    merge_word = spm.spm_rd_data;

    case (ex_out[1:0])
      2'd0:    byte_sel = spm.spm_rd_data[7:0];
      2'd1:    byte_sel = spm.spm_rd_data[15:8];
      2'd2:    byte_sel = spm.spm_rd_data[23:16];
      default: byte_sel = spm.spm_rd_data[31:24];
    endcase
    half_sel = ex_out[1] ? spm.spm_rd_data[31:16] : spm.spm_rd_data[15:0];

    case (op)
      MEM_OP_LDW:  load_data = spm.spm_rd_data;
      MEM_OP_LDH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LDHU: load_data = {16'h0000, half_sel};
      MEM_OP_LDB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LDBU: load_data = {24'h000000, byte_sel};
      default:     load_data = ex_out;
    endcase

    // Only the target lane of the freshly read word is replaced.
    if (op == MEM_OP_STB) begin
      merge_word[{ex_out[1:0], 3'b000} +: 8] = ex_mem_wr_data[7:0];
    end else if (op == MEM_OP_STH) begin
      merge_word[{ex_out[1], 4'b0000} +: 16] = ex_mem_wr_data[15:0];
    end
  end

  // ---------------------------------------------------------------------------
  // SPM control FSM (next state, merge buffer, SPM strobes, busy)
  // ---------------------------------------------------------------------------
  logic        spm_as_n;
  logic        spm_rw_sel;
  logic [31:0] spm_wdata;

  always_comb begin
    state_d    = state_q;
    merge_d    = merge_q;
    spm_as_n   = 1'b1;
    spm_rw_sel = SPM_READ;
    spm_wdata  = ex_mem_wr_data;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        if (access_ok) begin
          spm_as_n = 1'b0;
          if (is_sub_store) begin
            // Read phase of the RMW: upstream must hold the EX inputs so the
            // same store is presented again during the write phase.
            busy    = 1'b1;
            merge_d = merge_word;
            state_d = RMW_WR;
          end else if (op == MEM_OP_STW) begin
            spm_rw_sel = SPM_WRITE;
          end
        end
      end

      RMW_WR: begin
        spm_wdata = merge_q;
        if (flush) begin
          // Aborted: the merged word is dropped, never written.
          state_d = IDLE;
        end else if (!stall) begin
          spm_as_n   = 1'b0;
          spm_rw_sel = SPM_WRITE;
          state_d    = IDLE;
        end
        // Stalled: stay here with the strobe idle; the write goes out once.
      end

      default: state_d = IDLE;
    endcase
  end

  assign spm.spm_addr    = ex_out[31:2];
  assign spm.spm_as_     = spm_as_n;
  assign spm.spm_rw      = spm_rw_sel;
  assign spm.spm_wr_data = spm_wdata;

  // ---------------------------------------------------------------------------
  // MEM/WB register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en_d       = mem_en_q;
    mem_dst_addr_d = mem_dst_addr_q;
    mem_gpr_we_d   = mem_gpr_we_q;
    mem_out_d      = mem_out_q;
    miss_align_d   = miss_align_q;

    if (flush) begin
      mem_en_d       = 1'b0;
      mem_dst_addr_d = 5'd0;
      mem_gpr_we_d   = 1'b1;
      mem_out_d      = 32'h0000_0000;
      miss_align_d   = 1'b0;
    end else if (!stall && !busy) begin
      mem_en_d       = ex_en;
      mem_dst_addr_d = ex_dst_addr;
      // Stores never write a GPR; a misaligned access is cancelled outright.
      mem_gpr_we_d   = (is_store || miss) ? 1'b1 : ex_gpr_we_;
      mem_out_d      = is_load ? load_data : ex_out;
      miss_align_d   = ex_en && miss;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values computed before the edge, independent of the
  // order in which the simulator evaluates processes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      // NOTE: the merge buffer is a single word register, not a memory array,
      // so it is cheap to reset and guarantees a known value after reset.
      merge_q        <= 32'h0000_0000;
      mem_en_q       <= 1'b0;
      mem_dst_addr_q <= 5'd0;
      mem_gpr_we_q   <= 1'b1;
      mem_out_q      <= 32'h0000_0000;
      miss_align_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      merge_q        <= merge_d;
      mem_en_q       <= mem_en_d;
      mem_dst_addr_q <= mem_dst_addr_d;
      mem_gpr_we_q   <= mem_gpr_we_d;
      mem_out_q      <= mem_out_d;
      miss_align_q   <= miss_align_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_dst_addr = mem_dst_addr_q;
  assign mem_gpr_we_  = mem_gpr_we_q;
  assign mem_out      = mem_out_q;
  assign miss_align   = miss_align_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage. A behavioural SPM (falling-edge sampled,
// read-first) sits on the interface; a separate reference memory plus a
// rule-level model of the load/store semantics produces every expected value.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDW  = 4'd1;
  localparam logic [3:0] OP_LDH  = 4'd2;
  localparam logic [3:0] OP_LDHU = 4'd3;
  localparam logic [3:0] OP_LDB  = 4'd4;
  localparam logic [3:0] OP_LDBU = 4'd5;
  localparam logic [3:0] OP_STW  = 4'd6;
  localparam logic [3:0] OP_STH  = 4'd7;
  localparam logic [3:0] OP_STB  = 4'd8;

`ifdef MEM_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        ex_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [31:0] ex_out;
  logic        busy;
  logic        miss_align;
  logic        mem_en;
  logic [4:0]  mem_dst_addr;
  logic        mem_gpr_we_;
  logic [31:0] mem_out;

  int total = 0;
  int bad   = 0;

  mem_stage_if spm ();

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .ex_en          (ex_en),
    .ex_mem_op      (ex_mem_op),
    .ex_mem_wr_data (ex_mem_wr_data),
    .ex_dst_addr    (ex_dst_addr),
    .ex_gpr_we_     (ex_gpr_we_),
    .ex_out         (ex_out),
    .spm            (spm),
    .busy           (busy),
    .miss_align     (miss_align),
    .mem_en         (mem_en),
    .mem_dst_addr   (mem_dst_addr),
    .mem_gpr_we_    (mem_gpr_we_),
    .mem_out        (mem_out)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural SPM on the falling edge (256 words visible)
  // ---------------------------------------------------------------------------
  logic [31:0] spm_mem [256];
  int          wr_count = 0;
  logic        pre_clr  = 1'b0;
  logic        pre_we   = 1'b0;
  logic [7:0]  pre_idx  = 8'd0;
  logic [31:0] pre_val  = 32'd0;

  always @(negedge clk) begin
    if (pre_clr) begin
      for (int i = 0; i < 256; i++) spm_mem[i] <= 32'd0;
    end else if (pre_we) begin
      spm_mem[pre_idx] <= pre_val;
    end else if (!spm.spm_as_) begin
      if (spm.spm_rw == 1'b0) begin
        spm_mem[spm.spm_addr[7:0]] <= spm.spm_wr_data;
        wr_count <= wr_count + 1;
      end else begin
        spm.spm_rd_data <= spm_mem[spm.spm_addr[7:0]];
      end
    end
  end

  // Reference memory, updated only by the model below.
  logic [31:0] ref_mem [256];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic model_miss(input logic [3:0] op, input logic [31:0] a);
    logic word_op, half_op;
    word_op = (op == OP_LDW) || (op == OP_STW);
    half_op = (op == OP_LDH) || (op == OP_LDHU) || (op == OP_STH);
    return CHK_EN && ((word_op && (a % 4 != 0)) || (half_op && (a % 2 != 0)));
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] dst, input logic we_);
    ex_en = 1'b1; ex_mem_op = op; ex_out = a;
    ex_mem_wr_data = wd; ex_dst_addr = dst; ex_gpr_we_ = we_;
  endtask

  task automatic idle();
    ex_en = 1'b0; ex_mem_op = OP_NOP; ex_out = 32'd0;
    ex_mem_wr_data = 32'd0; ex_dst_addr = 5'd0; ex_gpr_we_ = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic preload(input int idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = 8'(idx); pre_val = val;
    ref_mem[idx] = val;
    @(negedge clk); #1;
    pre_we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues one EX/MEM entry, predicts everything from the reference model and
  // checks busy, strobe, write count and the MEM/WB result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] dst, input logic we_);
    logic        miss, is_load, is_sub, is_store, exp_busy, exp_as, exp_we;
    logic [31:0] word, exp_out, lane_val;
    int          idx, bsh, hsh, w0, exp_wr;
    idx      = int'(a[9:2]);
    bsh      = 8 * int'(a[1:0]);
    hsh      = 16 * int'(a[1]);
    miss     = model_miss(op, a);
    is_load  = op inside {OP_LDW, OP_LDH, OP_LDHU, OP_LDB, OP_LDBU};
    is_sub   = op inside {OP_STH, OP_STB};
    is_store = is_sub || (op == OP_STW);
    exp_busy = is_sub && !miss;
    exp_as   = !((is_load || is_store) && !miss);
    exp_we   = (is_store || miss) ? 1'b1 : we_;
    exp_wr   = (is_store && !miss) ? 1 : 0;
    word     = ref_mem[idx];
    exp_out  = a;
    case (op)
      OP_LDW: exp_out = word;
      OP_LDB, OP_LDBU: begin
        lane_val = (word >> bsh) & 32'hFF;
        exp_out  = (op == OP_LDB && lane_val >= 32'h80) ? lane_val + 32'hFFFF_FF00 : lane_val;
      end
      OP_LDH, OP_LDHU: begin
        lane_val = (word >> hsh) & 32'hFFFF;
        exp_out  = (op == OP_LDH && lane_val >= 32'h8000) ? lane_val + 32'hFFFF_0000 : lane_val;
      end
      default: ;
    endcase
    if (!miss) begin
      case (op)
        OP_STW: ref_mem[idx] = wd;
        OP_STB: ref_mem[idx] = (word & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
        OP_STH: ref_mem[idx] = (word & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
        default: ;
      endcase
    end

    w0 = wr_count;
    drive(op, a, wd, dst, we_);
    #1;
    total++; if (busy !== exp_busy) begin bad++;
      $display("FAIL busy op=%0d addr=%h: got %b expected %b", op, a, busy, exp_busy); end
    total++; if (spm.spm_as_ !== exp_as) begin bad++;
      $display("FAIL spm_as_ op=%0d addr=%h: got %b expected %b", op, a, spm.spm_as_, exp_as); end
    @(posedge clk); #1;
    if (exp_busy) begin
      total++; if (busy !== 1'b0) begin bad++;
        $display("FAIL busy_wr_phase op=%0d addr=%h: got %b expected 0", op, a, busy); end
      @(posedge clk); #1;
    end
    total++; if (wr_count - w0 != exp_wr) begin bad++;
      $display("FAIL spm_writes op=%0d addr=%h: got %0d expected %0d", op, a, wr_count - w0, exp_wr); end
    total++; if (mem_en !== 1'b1) begin bad++;
      $display("FAIL mem_en op=%0d: got %b expected 1", op, mem_en); end
    total++; if (mem_dst_addr !== dst) begin bad++;
      $display("FAIL mem_dst_addr op=%0d: got %0d expected %0d", op, mem_dst_addr, dst); end
    total++; if (mem_gpr_we_ !== exp_we) begin bad++;
      $display("FAIL mem_gpr_we_ op=%0d addr=%h: got %b expected %b", op, a, mem_gpr_we_, exp_we); end
    total++; if (miss_align !== miss) begin bad++;
      $display("FAIL miss_align op=%0d addr=%h: got %b expected %b", op, a, miss_align, miss); end
    if (!(is_load && miss)) begin
      total++; if (mem_out !== exp_out) begin bad++;
        $display("FAIL mem_out op=%0d addr=%h: got %h expected %h", op, a, mem_out, exp_out); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // A qualifying sub-store is presented while reset is held.
    drive(OP_STB, 32'h0000_0101, 32'hAB, 5'd3, 1'b1);
    @(posedge clk); #1;
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
    total++; if (mem_dst_addr !== 5'd0) begin bad++; $display("FAIL rst_dst: got %0d expected 0", mem_dst_addr); end
    total++; if (mem_gpr_we_ !== 1'b1) begin bad++; $display("FAIL rst_we_: got %b expected 1", mem_gpr_we_); end
    total++; if (mem_out !== 32'd0) begin bad++; $display("FAIL rst_out: got %h expected 0", mem_out); end
    total++; if (miss_align !== 1'b0) begin bad++; $display("FAIL rst_miss: got %b expected 0", miss_align); end
    total++; if (spm.spm_as_ !== 1'b1) begin bad++; $display("FAIL rst_as_: got %b expected 1", spm.spm_as_); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_byte();
    preload(32'h100 >> 2, 32'h80FF_1234);
    issue(OP_LDB,  32'h0000_0103, 32'd0, 5'd7, 1'b0);
    issue(OP_LDBU, 32'h0000_0103, 32'd0, 5'd8, 1'b0);
    issue(OP_LDH,  32'h0000_0102, 32'd0, 5'd9, 1'b0);
    issue(OP_LDHU, 32'h0000_0100, 32'd0, 5'd10, 1'b0);
  endtask

  task automatic test_stb_rmw();
    preload(32'h200 >> 2, 32'h1122_3344);
    issue(OP_STB, 32'h0000_0201, 32'h0000_00AB, 5'd4, 1'b0);
    total++; if (spm_mem[32'h200 >> 2] !== 32'h1122_AB44) begin bad++;
      $display("FAIL stb_word: got %h expected 1122ab44", spm_mem[32'h200 >> 2]); end
    issue(OP_LDW, 32'h0000_0200, 32'd0, 5'd4, 1'b0);
    idle();
  endtask

  task automatic test_stall_rmw();
    int w0;
    preload(32'h240 >> 2, 32'hCAFE_F00D);
    drive(OP_STH, 32'h0000_0242, 32'h0000_5A5A, 5'd2, 1'b1);
    @(posedge clk); #1;                 // now in the write phase
    w0 = wr_count;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (spm.spm_as_ !== 1'b1) begin bad++;
        $display("FAIL stall_as_ cycle=%0d: got %b expected 1", i, spm.spm_as_); end
      @(posedge clk); #1;
    end
    total++; if (wr_count != w0) begin bad++;
      $display("FAIL stall_no_write: got %0d expected %0d", wr_count - w0, 0); end
    stall = 1'b0;
    @(posedge clk); #1;
    total++; if (wr_count - w0 != 1) begin bad++;
      $display("FAIL stall_one_write: got %0d expected 1", wr_count - w0); end
    total++; if (mem_en !== 1'b1 || mem_gpr_we_ !== 1'b1) begin bad++;
      $display("FAIL stall_memwb: got en=%b we_=%b expected en=1 we_=1", mem_en, mem_gpr_we_); end
    idle();
    @(posedge clk); #1;
    total++; if (wr_count - w0 != 1) begin bad++;
      $display("FAIL stall_no_repeat: got %0d expected 1", wr_count - w0); end
    ref_mem[32'h240 >> 2] = (32'hCAFE_F00D & 32'h0000_FFFF) | (32'h5A5A << 16);
    issue(OP_LDW, 32'h0000_0240, 32'd0, 5'd1, 1'b0);
    idle();
  endtask

  task automatic test_flush_rmw();
    int w0;
    preload(32'h244 >> 2, 32'h0102_0304);
    drive(OP_STB, 32'h0000_0244, 32'h0000_00EE, 5'd6, 1'b1);
    @(posedge clk); #1;                 // now in the write phase
    w0 = wr_count;
    flush = 1'b1;
    #1;
    total++; if (spm.spm_as_ !== 1'b1) begin bad++;
      $display("FAIL flush_as_: got %b expected 1", spm.spm_as_); end
    @(posedge clk); #1;
    flush = 1'b0;
    idle();
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL flush_mem_en: got %b expected 0", mem_en); end
    total++; if (mem_out !== 32'd0) begin bad++; $display("FAIL flush_mem_out: got %h expected 0", mem_out); end
    total++; if (mem_gpr_we_ !== 1'b1) begin bad++; $display("FAIL flush_we_: got %b expected 1", mem_gpr_we_); end
    @(posedge clk); #1;
    total++; if (wr_count != w0) begin bad++;
      $display("FAIL flush_no_write: got %0d expected 0", wr_count - w0); end
    issue(OP_LDW, 32'h0000_0244, 32'd0, 5'd1, 1'b0);
    idle();
  endtask

  task automatic test_reset_mid_rmw();
    int w0;
    preload(32'h248 >> 2, 32'h5566_7788);
    drive(OP_STB, 32'h0000_0248, 32'h0000_0011, 5'd6, 1'b1);
    @(posedge clk); #1;                 // now in the write phase
    w0 = wr_count;
    reset = 1'b0;
    #1;
    total++; if (spm.spm_as_ !== 1'b1) begin bad++; $display("FAIL rstrmw_as_: got %b expected 1", spm.spm_as_); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstrmw_busy: got %b expected 0", busy); end
    total++; if (mem_en !== 1'b0 || mem_gpr_we_ !== 1'b1 || mem_out !== 32'd0 ||
                 mem_dst_addr !== 5'd0 || miss_align !== 1'b0) begin bad++;
      $display("FAIL rstrmw_outs: got en=%b we_=%b out=%h dst=%0d miss=%b expected 0/1/0/0/0",
               mem_en, mem_gpr_we_, mem_out, mem_dst_addr, miss_align); end
    @(posedge clk); #1;
    total++; if (wr_count != w0) begin bad++;
      $display("FAIL rstrmw_no_write: got %0d expected 0", wr_count - w0); end
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    issue(OP_LDW, 32'h0000_0248, 32'd0, 5'd1, 1'b0);
    idle();
  endtask

  task automatic test_passthrough();
    issue(OP_NOP, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5, 1'b0);
    idle();
  endtask

  task automatic test_back_to_back();
    preload(32'h24C >> 2, 32'h0000_0000);
    issue(OP_STH, 32'h0000_024E, 32'h0000_BEEF, 5'd1, 1'b1);
    issue(OP_STB, 32'h0000_024C, 32'h0000_007A, 5'd1, 1'b1);
    total++; if (spm_mem[32'h24C >> 2] !== 32'hBEEF_007A) begin bad++;
      $display("FAIL b2b_word: got %h expected beef007a", spm_mem[32'h24C >> 2]); end
    issue(OP_LDH, 32'h0000_024E, 32'd0, 5'd2, 1'b0);
    idle();
  endtask

  task automatic test_misalign();
    preload(32'h100 >> 2, 32'h80FF_1234);
    issue(OP_LDW, 32'h0000_0102, 32'd0, 5'd3, 1'b0);
    issue(OP_STH, 32'h0000_0101, 32'h0000_FFFF, 5'd3, 1'b1);
    issue(OP_LDW, 32'h0000_0100, 32'd0, 5'd3, 1'b0);
    idle();
  endtask

  task automatic test_random();
    int diffs;
    logic [3:0] op;
    for (int n = 0; n < 200; n++) begin
      op = 4'($urandom_range(0, 8));
      issue(op, 32'($urandom_range(0, 1023)), $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
    end
    idle();
    @(posedge clk); #1;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (spm_mem[i] !== ref_mem[i]) diffs++;
    total++; if (diffs != 0) begin bad++;
      $display("FAIL mem_image: got %0d differing words expected 0", diffs); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    pre_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pre_clr = 1'b0;

    test_reset();
    test_load_byte();
    test_stb_rmw();
    test_stall_rmw();
    test_flush_rmw();
    test_reset_mid_rmw();
    test_passthrough();
    test_back_to_back();
    if (CHK_EN) test_misalign();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between `ex_stage` and GPR write-back. It consumes the EX/MEM pipeline register and drives SPM port B: aligned word accesses directly, sub-word loads by lane extraction, and sub-word stores by a two-cycle read-modify-write. It registers the MEM/WB outputs (`mem_out`, `mem_dst_addr`, `mem_gpr_we_`, `mem_en`) that feed the GPR write port.

## Interface
- No parameters. Widths come from the shared headers: `WORD_DATA_BUS` 32, `WORD_ADDR_BUS` 30, `REG_ADDR_BUS` 5, `MEM_OP_BUS` 4.
- `clk`  in  1  pipeline clock. SPM is clocked by `clk_` (inverted).
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `stall`  in  1  hold the MEM/WB register and suppress SPM access.
- `flush`  in  1  load a bubble and abort any pending RMW.
- `ex_en`  in  1  EX/MEM entry valid.
- `ex_mem_op`  in  4  NOP, LDW, LDH, LDHU, LDB, LDBU, STW, STH, STB.
- `ex_mem_wr_data`  in  32  store data, right-justified.
- `ex_dst_addr`  in  5  GPR destination.
- `ex_gpr_we_`  in  1  GPR write enable, active-low.
- `ex_out`  in  32  ALU result, which is the byte address for memory ops.
- `spm_rd_data`  in  32  SPM port B read data.
- `spm_addr`  out  30  word address, `ex_out[31:2]`.
- `spm_as_`  out  1  address strobe, active-low.
- `spm_rw`  out  1  `READ`/`WRITE`.
- `spm_wr_data`  out  32  write data.
- `busy`  out  1  combinational stall request to upstream stages.
- `miss_align`  out  1  registered misalignment flag.
- `mem_en`  out  1  MEM/WB entry valid.
- `mem_dst_addr`  out  5  GPR write address.
- `mem_gpr_we_`  out  1  GPR write enable, active-low.
- `mem_out`  out  32  write-back data.

## Operation
- **Memory model.** Little-endian. Byte lane is `ex_out[1:0]`. Halfword lane is `ex_out[1]`.
- **Access control.** The stage accesses SPM only when `ex_en=1`, the op is not NOP, `stall=0`, `flush=0` and no misalignment is detected. Otherwise `spm_as_=1`.
- **Loads.** SPM read in the same cycle (SPM samples on the falling `clk` edge).
  - LDW passes the word unchanged.
  - LDB and LDH sign-extend the selected lane.
  - LDBU and LDHU zero-extend it.
- **Non-memory ops.** `mem_out=ex_out`.
- **STW.** Single-cycle write of `ex_mem_wr_data`.
- **STB/STH read-modify-write.** FSM with states IDLE and RMW_WR.
  - IDLE with a qualifying sub-word store: issue an SPM read and raise `busy=1`. At the next `clk` edge, latch into a merge buffer the read word with the target lane replaced by `ex_mem_wr_data[7:0]` or `[15:0]`, then go to RMW_WR.
  - RMW_WR: issue an SPM write of the merge buffer with `busy=0`. Upstream has held the EX inputs. Return to IDLE at the edge.
- **Store write-back.** Stores always register `mem_gpr_we_=1`. `mem_out` is don't-care and is driven as `ex_out`.
- **MEM/WB register update.**
  - Updates every edge where `stall=0` and `busy=0`.
  - `flush=1` loads a bubble: `mem_en=0`, `mem_gpr_we_=1`, `mem_out=0`, `mem_dst_addr=0`.
- **Flush or reset in RMW_WR.** Go to IDLE and suppress the write.
- **Stall in RMW_WR.** Hold RMW_WR with `spm_as_=1`. The write is issued once, after release.

## Timing
- **Reset values.** `mem_en=0`, `mem_dst_addr=0`, `mem_gpr_we_=1`, `mem_out=0`, `miss_align=0`, FSM=IDLE, merge buffer=0.
- **Reset-driven combinational outputs.** While in reset, `spm_as_=1` and `busy=0`.
- **Latency.**
  - Loads, STW and non-memory ops: 1 cycle from EX/MEM to MEM/WB.
  - STB/STH: 2 cycles. `busy` is high for exactly the first.
- **`busy` logic.** `busy` depends only on state and current EX inputs, with no flop in its path, so it asserts in the same cycle the store arrives.
- **Simultaneous inputs.** `flush` has priority over `stall`, and `stall` over a normal update.
- **Back-to-back stores.** A second sub-word store after RMW_WR starts a fresh RMW with no idle cycle.

## Configuration
- **`MEM_MISALIGN_CHK_EN` defined.** Misalignment is LDW/STW with `ex_out[1:0]!=0`, or LDH/LDHU/STH with `ex_out[0]=1`. On misalignment:
  - no SPM access;
  - registered `miss_align=1`;
  - `mem_gpr_we_=1`;
  - `mem_en` is still registered.
- **Macro undefined.** `miss_align` is tied to 0. Offending low address bits are ignored (word/halfword rounded down) and the access proceeds.

## Test plan
- **Reset.** Assert `reset=0` mid-RMW (state RMW_WR) -> no SPM write, all outputs at reset values, `spm_as_=1`.
- **LDB / LDBU.** SPM word 0x80FF1234 at 0x100:
  - LDB from 0x103 -> `mem_out=0xFFFFFF80` one cycle later;
  - LDBU from 0x103 -> `mem_out=0x00000080`;
  - both with `mem_gpr_we_=0`.
- **STB RMW.** STB 0xAB to 0x101 over word 0x11223344:
  - `busy=1` for one cycle, then a write of 0x1122AB44;
  - a subsequent LDW returns 0x1122AB44.
- **Stall and flush across an RMW.**
  - `stall=1` held 3 cycles in RMW_WR -> `spm_as_=1` throughout; exactly one write after release.
  - `flush` in RMW_WR -> no write, `mem_en=0`.
- **Pass-through.** Non-memory op: `ex_out=0xDEADBEEF`, `ex_dst_addr=5`, `ex_gpr_we_=0` -> `mem_out=0xDEADBEEF`, `mem_dst_addr=5`, `mem_en=1`, `spm_as_=1`.
- **Misalignment** (`MEM_MISALIGN_CHK_EN` defined). LDW at 0x102 -> `miss_align=1`, `spm_as_=1`, `mem_gpr_we_=1`.
